conv_row_scheduler: RTL and testbench

- Sequencing controller for the 128-lane 1-D convolution array (130 input pixels, 3-tap kernel, 128 8-bit results).
- Walks a frame stored as 1040-bit tile words in a source line memory.
- Per tile: fetches the word, holds it on the array inputs for the array's pipeline latency, captures the 1024-bit result and writes it to a destination memory with backpressure.
- Sits between the frame buffers and the convolution array; driven by a host start/done handshake.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_tile_counter.sv | 46 ++++
 rtl/conv_row_scheduler.sv | 128 ++++++++++++
 tb/tb_conv_row_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and helpers for the convolution-array schedulers.
package conv_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned LANES  = 128;
  localparam int unsigned TAPS   = 3;

  localparam int unsigned DATA_W = (LANES + TAPS - 1) * PIX_W;
  localparam int unsigned RES_W  = LANES * PIX_W;
  localparam int unsigned WGT_W  = TAPS * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } sched_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tile_counter.sv
// Row/tile position of a raster walk over a frame, its linear address and last-tile flag.
module conv_tile_counter
  import conv_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned TILES  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned TW = cnt_width(TILES);
  localparam int unsigned RW = cnt_width(ROWS);

  logic [TW-1:0] tile;
  logic [RW-1:0] row;
  logic          tile_last;
  logic          row_last;

  assign tile_last = (tile == TW'(TILES - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign last      = tile_last && row_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tile <= '0;
      row  <= '0;
    end else if (advance) begin
      if (tile_last) begin
        tile <= '0;
        row  <= row_last ? '0 : row + 1'b1;
      end else begin
        tile <= tile + 1'b1;
      end
    end
  end

  // Computed at 32 bits, then truncated to the memory address width.
  assign addr = ADDR_W'(32'(row) * TILES + 32'(tile));

endmodule

// File: rtl/conv_row_scheduler.sv
// Tile sequencer for the 1-D convolution array: read tile, hold it for the array
// latency, capture the result and write it back under destination backpressure.
module conv_row_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned TILES    = 4,
  parameter int unsigned CONV_LAT = 2,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WGT_W-1:0]  weight,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] conv_data,
  output logic [WGT_W-1:0]  conv_weight,
  input  logic [RES_W-1:0]  conv_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RES_W-1:0]  wr_data,
  input  logic              wr_ready
);

  localparam int unsigned LW = cnt_width(CONV_LAT);

  sched_state_t      state;
  sched_state_t      state_nxt;
  logic [LW-1:0]     lat_cnt;
  logic              lat_done;
  logic              cnt_clear;
  logic              cnt_advance;
  logic              tile_last;
  logic [ADDR_W-1:0] tile_addr;

  conv_tile_counter #(
    .ROWS   (ROWS),
    .TILES  (TILES),
    .ADDR_W (ADDR_W)
  ) u_tile_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .addr    (tile_addr),
    .last    (tile_last)
  );

  assign rd_addr  = tile_addr;
  assign wr_addr  = tile_addr;
  assign lat_done = (lat_cnt == LW'(CONV_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_clear = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        rd_en     = 1'b1;
        state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (rd_valid) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (lat_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          cnt_advance = 1'b1;
          state_nxt   = tile_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Array-facing registers only move on their own load events, so the array
  // sees stable operands for the whole latency window.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt     <= '0;
      conv_data   <= '0;
      conv_weight <= '0;
      wr_data     <= '0;
    end else begin
      if (state == S_IDLE && start) conv_weight <= weight;
      if (state == S_WAIT_RD && rd_valid) begin
        conv_data <= rd_data;
        lat_cnt   <= '0;
      end else if (state == S_COMPUTE) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (state == S_COMPUTE && lat_done) wr_data <= conv_result;
    end
  end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Self-checking bench: memory/array models around conv_row_scheduler and a
// raster-order scoreboard of reads and convolved writes.
module tb_conv_row_scheduler;
  import conv_pkg::*;

  localparam int ROWS     = 2;
  localparam int TILES    = 2;
  localparam int CONV_LAT = 2;
  localparam int ADDR_W   = 8;
  localparam int NT       = ROWS * TILES;
  localparam int TILE_CYC = CONV_LAT + 3;
  localparam int BASE_LEN = NT * TILE_CYC;

  logic              clk;
  logic              reset;
  logic              start;
  logic [WGT_W-1:0]  weight;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] conv_data;
  logic [WGT_W-1:0]  conv_weight;
  logic [RES_W-1:0]  conv_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RES_W-1:0]  wr_data;
  logic              wr_ready;

  conv_row_scheduler #(
    .ROWS     (ROWS),
    .TILES    (TILES),
    .CONV_LAT (CONV_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .weight      (weight),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .conv_data   (conv_data),
    .conv_weight (conv_weight),
    .conv_result (conv_result),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scenario knobs, written only by the main sequence.
  logic [DATA_W-1:0] src [NT];
  logic [WGT_W-1:0]  exp_w;
  int frame_id;
  int stall_addr, stall_n, delay_addr, delay_n, spur_addr;

  // Scoreboard state, written only by the monitor.
  int ridx, widx, first_rd, busy_cnt;
  int wr_cnt [NT];
  logic [RES_W-1:0] wr_log [NT];

  // Last tile word the DUT should hold, written only by the source responder.
  logic              cd_known;
  logic [DATA_W-1:0] cd_exp;
  int                cd_addr;

  int checks, errors;

  // Lane k = w0*p[k] + w1*p[k+1] + w2*p[k+2], 8-bit wrap.
  function automatic logic [RES_W-1:0] conv_model(input logic [DATA_W-1:0] px,
                                                  input logic [WGT_W-1:0]  w);
    logic [RES_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(LANES); k++)
      r[8*k +: 8] = px[8*k +: 8] * w[7:0] + px[8*(k+1) +: 8] * w[15:8]
                  + px[8*(k+2) +: 8] * w[23:16];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] want);
    int b;
    checks++;
    if (got !== want) begin
      errors++;
      if (got[DATA_W-1:64] === '0 && want[DATA_W-1:64] === '0) begin
        $display("FAIL %s: got %0h, want %0h", name, got[63:0], want[63:0]);
      end else begin
        b = 0;
        while (b < int'(DATA_W / 8) && got[8*b +: 8] === want[8*b +: 8]) b++;
        if (b >= int'(DATA_W / 8)) b = 0;
        $display("FAIL %s: byte %0d got %0h, want %0h", name, b, got[8*b +: 8], want[8*b +: 8]);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
    chk({tag, "_done"}, DATA_W'(done), '0);
    chk({tag, "_rd_en"}, DATA_W'(rd_en), '0);
    chk({tag, "_wr_en"}, DATA_W'(wr_en), '0);
    chk({tag, "_rd_addr"}, DATA_W'(rd_addr), '0);
    chk({tag, "_wr_addr"}, DATA_W'(wr_addr), '0);
    chk({tag, "_conv_data"}, conv_data, '0);
    chk({tag, "_conv_weight"}, DATA_W'(conv_weight), '0);
    chk({tag, "_wr_data"}, DATA_W'(wr_data), '0);
  endtask

  // Array: two edges from conv_data change to a valid result.
  logic [RES_W-1:0] arr_stage;
  initial begin
    conv_result = '0;
    arr_stage   = '0;
    forever begin
      @(negedge clk);
      conv_result = arr_stage;
      arr_stage   = conv_model(conv_data, conv_weight);
    end
  end

  // Source memory: returns the word rd_delay cycles after rd_en, optionally
  // followed by a junk beat while the scheduler is computing.
  initial begin
    int a, dly;
    rd_valid = 1'b0;
    rd_data  = '0;
    cd_known = 1'b0;
    cd_exp   = '0;
    cd_addr  = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        cd_known = 1'b0;
      end else if (rd_en) begin
        a   = int'(rd_addr) % NT;
        dly = (a == delay_addr) ? 1 + delay_n : 1;
        repeat (dly) @(posedge clk);
        #1;
        rd_valid = 1'b1;
        rd_data  = src[a];
        @(posedge clk);
        #1;
        cd_exp   = src[a];
        cd_addr  = a;
        cd_known = 1'b1;
        if (a == spur_addr) begin
          rd_data = '1;
          @(posedge clk);
          #1;
        end
        rd_valid = 1'b0;
      end
    end
  end

  // Destination: ready except for stall_n WRITE cycles on stall_addr per frame.
  initial begin
    int seen, left;
    seen     = -1;
    left     = 0;
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (seen != frame_id) begin
        seen = frame_id;
        left = stall_n;
      end
      if (wr_en && int'(wr_addr) == stall_addr && left > 0) begin
        wr_ready = 1'b0;
        left--;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  task automatic monitor();
    int seen;
    logic pv_en, pv_rdy;
    logic [ADDR_W-1:0] pv_addr;
    logic [RES_W-1:0]  pv_data;
    seen = -1;
    pv_en = 1'b0;
    pv_rdy = 1'b1;
    pv_addr = '0;
    pv_data = '0;
    forever begin
      @(negedge clk);
      if (seen != frame_id) begin
        seen = frame_id;
        ridx = 0;
        widx = 0;
        first_rd = -1;
        busy_cnt = 0;
        for (int i = 0; i < NT; i++) wr_cnt[i] = 0;
      end
      if (reset) begin
        pv_en = 1'b0;
      end else begin
        if (rd_en) begin
          chk("rd_addr", DATA_W'(rd_addr), DATA_W'(ridx));
          if (ridx == 0) first_rd = cyc;
          ridx++;
        end
        if (pv_en && !pv_rdy) begin
          chk("hold_wr_en", DATA_W'(wr_en), DATA_W'(1));
          chk("hold_wr_addr", DATA_W'(wr_addr), DATA_W'(pv_addr));
          chk("hold_wr_data", DATA_W'(wr_data), DATA_W'(pv_data));
        end
        if (wr_en && wr_ready) begin
          chk("wr_addr", DATA_W'(wr_addr), DATA_W'(widx));
          if (widx < NT) chk("wr_data", DATA_W'(wr_data), DATA_W'(conv_model(src[widx], exp_w)));
          wr_cnt[int'(wr_addr) % NT]++;
          wr_log[int'(wr_addr) % NT] = wr_data;
          widx++;
        end
        if (busy) begin
          chk("conv_weight", DATA_W'(conv_weight), DATA_W'(exp_w));
          busy_cnt++;
        end
        if (busy && cd_known) chk("conv_data", conv_data, cd_exp);
        if (rd_en || wr_en) chk("busy_active", DATA_W'(busy), DATA_W'(1));
        if (done) chk("busy_in_done", DATA_W'(busy), '0);
        pv_en   = wr_en;
        pv_rdy  = wr_ready;
        pv_addr = wr_addr;
        pv_data = wr_data;
      end
    end
  endtask

  task automatic wait_done(input int lim, output int d);
    d = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    checks++;
    if (d < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, want a done pulse", lim);
    end
    #1;
  endtask

  task automatic frame_checks(input string tag, input int d, input int len);
    chk({tag, "_frame_len"}, DATA_W'(d - first_rd), DATA_W'(len));
    chk({tag, "_busy_cycles"}, DATA_W'(busy_cnt), DATA_W'(len));
    chk({tag, "_reads"}, DATA_W'(ridx), DATA_W'(NT));
    chk({tag, "_writes"}, DATA_W'(widx), DATA_W'(NT));
    for (int i = 0; i < NT; i++) chk({tag, "_write_once"}, DATA_W'(wr_cnt[i]), DATA_W'(1));
  endtask

  initial begin
    int d, d2;
    logic found, quiet;
    logic [RES_W-1:0] res;
    checks = 0;
    errors = 0;
    frame_id = 0;
    reset = 1'b1;
    start = 1'b0;
    weight = '0;
    exp_w = '0;
    stall_addr = -1;
    stall_n = 0;
    delay_addr = -1;
    delay_n = 0;
    spur_addr = -1;
    for (int a = 0; a < NT; a++)
      for (int i = 0; i < int'(LANES + TAPS - 1); i++)
        src[a][8*i +: 8] = 8'(i + 16 * a);
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;

    // Frame A: ideal memories; start and weight disturbed mid-frame.
    @(negedge clk);
    frame_id++;
    exp_w = 24'h030201;
    weight = exp_w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    weight = 24'hABCDEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, d);
    frame_checks("A", d, BASE_LEN);
    res = wr_log[0];
    chk("A_addr0_lane0", DATA_W'(res[7:0]), DATA_W'(8));
    chk("A_addr0_lane1", DATA_W'(res[15:8]), DATA_W'(14));
    chk("A_addr0_lane127", DATA_W'(res[1023:1016]), DATA_W'(2));

    // Frame B: start held across DONE and the next IDLE cycle; stall, late read, junk beat.
    start = 1'b1;
    exp_w = 24'h030201;
    weight = exp_w;
    stall_addr = 1;
    stall_n = 7;
    delay_addr = 2;
    delay_n = 4;
    spur_addr = 2;
    frame_id++;
    @(negedge clk);
    chk("done_one_cycle", DATA_W'(done), '0);
    chk("idle_after_done", DATA_W'(busy), '0);
    @(negedge clk);
    start = 1'b0;
    wait_done(400, d2);
    chk("B_first_read", DATA_W'(first_rd), DATA_W'(d + 2));
    frame_checks("B", d2, BASE_LEN + 7 + 4);
    res = wr_log[2];
    chk("B_addr2_lane0", DATA_W'(res[7:0]), DATA_W'(200));

    // Frame C: reset while tile 1 is in the array window.
    stall_addr = -1;
    stall_n = 0;
    delay_addr = -1;
    delay_n = 0;
    spur_addr = -1;
    @(negedge clk);
    frame_id++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cd_known && cd_addr == 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("C_reached_compute", DATA_W'(found), DATA_W'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid");
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rd_en || wr_en || busy) quiet = 1'b0;
    end
    chk("C_quiet_after_reset", DATA_W'(quiet), DATA_W'(1));

    // Frame D: clean frame after the abort.
    @(negedge clk);
    frame_id++;
    exp_w = 24'h010203;
    weight = exp_w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, d);
    frame_checks("D", d, BASE_LEN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
